// File: rtl/pipe_column_generator_pkg.sv
// rtl/pipe_column_generator_pkg.sv - shared playfield constants, column type and LFSR helpers
package pipe_column_generator_pkg;

    localparam int PIPE_OPENING = 24;
    localparam int PLAYFIELD_H  = 80;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

    typedef logic [6:0] col_t;

    typedef enum logic {
        S_GEN  = 1'b0,
        S_FULL = 1'b1
    } gen_state_t;

    // Right-shifting Galois step; a non-zero state can never map to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with level output and synchronous clear
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: empty/level gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pipe_column_generator.sv
// rtl/pipe_column_generator.sv - pseudo-random playable pipe column stream for the game datapath
module pipe_column_generator #(
    parameter int          GAP_COLS   = 12,
    parameter int          MIN_H      = 10,
    parameter int          MAX_H      = 50,
    parameter int          MAX_STEP   = 20,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DEF_SEED   = pipe_column_generator_pkg::DEF_SEED
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clear,
    input  logic                          seed_load,
    input  logic [15:0]                   seed_in,
    input  logic                          req,
    output logic [6:0]                    col_height,
    output logic                          col_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);
    import pipe_column_generator_pkg::*;

    localparam int                 CNT_W    = $clog2(GAP_COLS + 1);
    localparam int                 LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]         SPAN8    = 8'(MAX_H - MIN_H);
    localparam logic [7:0]         MIN8     = 8'(MIN_H);
    localparam logic [7:0]         STEP8    = 8'(MAX_STEP);
    localparam logic [7:0]         MID8     = 8'((MIN_H + MAX_H) / 2);
    localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(GAP_COLS);

    logic [15:0]      lfsr;
    logic [15:0]      seed_eff;
    gen_state_t       state;
    gen_state_t       state_nxt;
    logic [7:0]       prev_h;
    logic [7:0]       cand_h;
    logic [7:0]       diff;
    logic             cand_ok;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] col_cnt;
    col_t             head;
    logic             full;
    logic             empty;

    assign seed_eff = (seed_load && seed_in != 16'h0000) ? seed_in : DEF_SEED;

    // Candidate height and its distance from the previous pipe, all 8-bit unsigned.
    assign cand_h  = MIN8 + {2'b00, lfsr[5:0]};
    assign diff    = (cand_h >= prev_h) ? (cand_h - prev_h) : (prev_h - cand_h);
    assign cand_ok = ({2'b00, lfsr[5:0]} <= SPAN8) && (diff <= STEP8);

    assign push = !clear && (state == S_GEN) && cand_ok && !full;
    assign pop  = !clear && req && (col_cnt == '0) && !empty;

    sync_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .push      (push),
        .push_data (cand_h[6:0]),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr   <= DEF_SEED;
            prev_h <= MID8;
            state  <= S_GEN;
        end else if (clear) begin
            lfsr   <= seed_eff;
            prev_h <= MID8;
            state  <= S_GEN;
        end else begin
            lfsr  <= lfsr_next(lfsr);
            state <= state_nxt;
            if (push) prev_h <= cand_h;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_GEN:   if (push && !pop && fifo_level == LW'(FIFO_DEPTH - 1)) state_nxt = S_FULL;
            S_FULL:  if (pop) state_nxt = S_GEN;
            default: state_nxt = S_GEN;
        endcase
    end

    // One pipe slot, then GAP_COLS sky columns; an empty FIFO keeps the slot pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_height <= '0;
            col_valid  <= 1'b0;
            col_cnt    <= '0;
            underflow  <= 1'b0;
        end else if (clear) begin
            col_height <= '0;
            col_valid  <= 1'b0;
            col_cnt    <= '0;
            underflow  <= 1'b0;
        end else begin
            col_valid <= req;
            if (req) begin
                if (col_cnt == '0) begin
                    if (!empty) begin
                        col_height <= head;
                        col_cnt    <= CNT_W'(1);
                    end else begin
                        col_height <= '0;
                        underflow  <= 1'b1;
                    end
                end else begin
                    col_height <= '0;
                    col_cnt    <= (col_cnt == GAP_LAST) ? '0 : col_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_column_generator.sv
// tb/tb_pipe_column_generator.sv - scoreboard and vector-table bench for pipe_column_generator
module tb_pipe_column_generator;
    import pipe_column_generator_pkg::*;

    localparam int GAP      = 3;
    localparam int MIN_H    = 10;
    localparam int MAX_H    = 50;
    localparam int MAX_STEP = 20;
    localparam int DEPTH    = 4;
    localparam int MID      = (MIN_H + MAX_H) / 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        req = 1'b0;
    logic [6:0]  col_height;
    logic        col_valid;
    logic [2:0]  fifo_level;
    logic        underflow;

    int n_vec = 0;
    int n_bad = 0;
    int n_pulses = 0;

    typedef struct { int h; int unf; } exp_t;
    exp_t exp_q[$];

    int          m_q[$];
    int          m_cnt;
    int          m_prev;
    int          m_unf;
    int          last_pipe;
    bit          m_full;
    logic [15:0] m_lfsr;

    typedef struct {
        logic        clr;
        logic        sl;
        logic [15:0] seed;
        logic        rq;
        int          exp_valid;
        int          exp_h;
        int          exp_unf;
        int          exp_lvl;
        int          exp_lfsr;
    } vec_t;

    always #5 clk = ~clk;

    pipe_column_generator #(
        .GAP_COLS   (GAP),
        .MIN_H      (MIN_H),
        .MAX_H      (MAX_H),
        .MAX_STEP   (MAX_STEP),
        .FIFO_DEPTH (DEPTH),
        .DEF_SEED   (16'hACE1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .req        (req),
        .col_height (col_height),
        .col_valid  (col_valid),
        .fifo_level (fifo_level),
        .underflow  (underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset(input logic [15:0] s);
        m_q.delete();
        exp_q.delete();
        m_cnt     = 0;
        m_prev    = MID;
        m_unf     = 0;
        m_full    = 1'b0;
        m_lfsr    = s;
        last_pipe = MID;
    endtask

    task automatic model_step();
        bit popped = 1'b0;
        int eh, cand, h, d;
        if (req) begin
            eh = 0;
            if (m_cnt == 0) begin
                if (m_q.size() > 0) begin
                    eh = m_q.pop_front();
                    popped = 1'b1;
                    m_cnt = 1;
                end else begin
                    m_unf = 1;
                end
            end else begin
                m_cnt = (m_cnt == GAP) ? 0 : m_cnt + 1;
            end
            exp_q.push_back('{h: eh, unf: m_unf});
        end
        if (!m_full) begin
            cand = int'(m_lfsr[5:0]);
            h = MIN_H + cand;
            d = (h > m_prev) ? h - m_prev : m_prev - h;
            if (cand <= MAX_H - MIN_H && d <= MAX_STEP) begin
                m_q.push_back(h);
                m_prev = h;
                if (m_q.size() == DEPTH) m_full = 1'b1;
            end
        end else if (popped) begin
            m_full = 1'b0;
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic sb_check();
        exp_t e;
        int   h, d;
        chk("fifo_level", int'(fifo_level), m_q.size());
        chk("underflow", int'(underflow), m_unf);
        if (col_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("col_height", int'(col_height), e.h);
                chk("col_underflow", int'(underflow), e.unf);
            end
            h = int'(col_height);
            if (h != 0) begin
                d = (h > last_pipe) ? h - last_pipe : last_pipe - h;
                chk("pipe_in_range", int'(h >= MIN_H && h <= MAX_H), 1);
                chk("pipe_step", int'(d <= MAX_STEP), 1);
                last_pipe = h;
            end
        end else if (exp_q.size() > 0) begin
            chk("missing_valid", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic tick();
        if (!resetn)     model_reset(16'hACE1);
        else if (clear)  model_reset((seed_load && seed_in != 16'h0000) ? seed_in : 16'hACE1);
        else             model_step();
        @(negedge clk);
        if (resetn) sb_check();
    endtask

    task automatic wait_level(input int lvl, input int budget);
        for (int i = 0; i < budget && int'(fifo_level) != lvl; i++) tick();
        chk("wait_level", int'(fifo_level), lvl);
    endtask

    task automatic do_clear(input logic sl, input logic [15:0] s);
        clear = 1'b1; seed_load = sl; seed_in = s; req = 1'b0;
        tick();
        clear = 1'b0; seed_load = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int p0, saw_pipe;

        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b1, 0, 0, 0, 0, 32'hACE1};
        vecs[1] = '{1'b1, 1'b1, 16'h1234, 1'b0, 0, 0, 0, 0, 32'h1234};
        vecs[2] = '{1'b1, 1'b0, 16'h1234, 1'b1, 0, 0, 0, 0, 32'hACE1};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 0, 1, -1, -1};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 1, -1, -1};
        vecs[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 0, 32'hACE1};

        // Reset state, then idle fill to full.
        repeat (3) tick();
        chk("rst_height", int'(col_height), 0);
        chk("rst_valid", int'(col_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_underflow", int'(underflow), 0);
        resetn = 1'b1;
        wait_level(DEPTH, 300);
        chk("state_full", int'(dut.state), int'(S_FULL));
        repeat (10) tick();
        chk("level_holds_full", int'(fifo_level), DEPTH);

        // Asynchronous reset with the FIFO at level 3.
        req = 1'b1; tick(); req = 1'b0;
        chk("pop_level", int'(fifo_level), DEPTH - 1);
        chk("pop_pipe_nonzero", int'(col_height != 0), 1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_height", int'(col_height), 0);
        chk("arst_valid", int'(col_valid), 0);
        chk("arst_level", int'(fifo_level), 0);
        chk("arst_underflow", int'(underflow), 0);
        model_reset(16'hACE1);
        repeat (2) tick();
        resetn = 1'b1;
        wait_level(DEPTH, 300);

        // Gap pattern: P,0,0,0,P,0,0,0,P.
        p0 = n_pulses;
        for (int i = 0; i < 9; i++) begin
            req = 1'b1; tick(); req = 1'b0;
            chk("gap_valid", int'(col_valid), 1);
            if (i % (GAP + 1) == 0) chk("gap_pipe", int'(col_height >= MIN_H && col_height <= MAX_H), 1);
            else                    chk("gap_zero", int'(col_height), 0);
            for (int k = 0; k < 4; k++) tick();
            chk("gap_valid_low", int'(col_valid), 0);
        end
        chk("gap_pulses", n_pulses - p0, 9);

        // Vector table: clear priority, seed selection, underflow sticky.
        foreach (vecs[i]) begin
            clear = vecs[i].clr; seed_load = vecs[i].sl; seed_in = vecs[i].seed; req = vecs[i].rq;
            tick();
            chk("vec_valid", int'(col_valid), vecs[i].exp_valid);
            chk("vec_height", int'(col_height), vecs[i].exp_h);
            chk("vec_underflow", int'(underflow), vecs[i].exp_unf);
            if (vecs[i].exp_lvl >= 0)  chk("vec_level", int'(fifo_level), vecs[i].exp_lvl);
            if (vecs[i].exp_lfsr >= 0) chk("vec_lfsr", int'(dut.lfsr), vecs[i].exp_lfsr);
            if (vecs[i].clr)           chk("vec_col_cnt", int'(dut.col_cnt), 0);
        end
        clear = 1'b0; seed_load = 1'b0; req = 1'b0;

        // Underflow: back-to-back requests straight after clear.
        do_clear(1'b0, 16'h0000);
        req = 1'b1; tick();
        chk("uf_height", int'(col_height), 0);
        chk("uf_flag", int'(underflow), 1);
        chk("uf_col_cnt", int'(dut.col_cnt), 0);
        saw_pipe = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (col_height != 0) saw_pipe = 1;
        end
        req = 1'b0;
        chk("uf_saw_pipe", saw_pipe, 1);
        chk("uf_sticky", int'(underflow), 1);

        // Seeded sequence.
        do_clear(1'b1, 16'h1234);
        chk("seed_lfsr", int'(dut.lfsr), 16'h1234);
        for (int i = 0; i < 300; i++) begin
            req = 1'b1; tick(); req = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end

        // Long run with the default seed.
        do_clear(1'b0, 16'h0000);
        chk("def_lfsr", int'(dut.lfsr), 16'hACE1);
        for (int i = 0; i < 5000; i++) begin
            req = 1'b1; tick(); req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_column_generator.md
Name: pipe_column_generator

Overview:
- Generates the stream of pipe columns that the game datapath shifts into its playfield vector, replacing the fixed obstacle pattern with pseudo-random, playable pipe heights.
- Sits directly upstream of the datapath. On each column-shift strobe it hands over one 7-bit column value:
  - 0 means empty sky.
  - Non-zero is the bottom edge of the pipe opening; the opening is 24 px, as in the datapath collision check.
- Internally, an LFSR and a rejection filter prefill a small FIFO, so a request is never stalled by filtering.

Parameters:
- GAP_COLS, 12, number of empty (0) columns emitted between consecutive pipe columns.
- MIN_H, 10, lowest allowed opening height (pixels).
- MAX_H, 50, highest allowed opening height; MAX_H-MIN_H must be ≤ 63.
- MAX_STEP, 20, largest allowed |h(n) - h(n-1)| between consecutive pipes.
- FIFO_DEPTH, 4, prefetch depth (power of 2).
- DEF_SEED, 16'hACE1, LFSR value after reset, and the substitute used for a zero seed.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- clear  in  1  synchronous restart; driven from the control FSM start state
- seed_load  in  1  on a clear cycle, load seed_in instead of DEF_SEED
- seed_in  in  16  user seed (e.g. switches or free-running counter)
- req  in  1  one-cycle strobe: datapath wants the next column
- col_height  out  7  column value; 0 = no pipe
- col_valid  out  1  one-cycle pulse, col_height is meaningful
- fifo_level  out  3  current FIFO occupancy (debug/LEDR)
- underflow  out  1  sticky: a pipe slot found the FIFO empty

Behaviour:
- Reset (resetn low, asynchronous):
  - lfsr=DEF_SEED; FIFO empty; col_cnt=0; prev_h=(MIN_H+MAX_H)/2; gen state S_GEN.
  - Outputs: col_height=0, col_valid=0, underflow=0, fifo_level=0.
- clear (synchronous, highest priority):
  - Same values as reset, except lfsr=seed_in when seed_load=1 and seed_in≠0; otherwise DEF_SEED.
  - A req in the same cycle is ignored: no col_valid in the following cycle.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right.
  - Advances exactly once every clock when not in reset/clear.
  - It can never hold zero.
- Generator FSM:
  - S_GEN: each cycle, cand=lfsr[5:0]. Accept if cand ≤ MAX_H-MIN_H and |MIN_H+cand - prev_h| ≤ MAX_STEP.
  - On accept: push MIN_H+cand and set prev_h to that value. If the FIFO becomes full, go to S_FULL.
  - On reject: push nothing; the LFSR advance provides the next candidate.
  - S_FULL: no pushes; return to S_GEN on the cycle after any pop.
  - Simultaneous push and pop on the same cycle is legal; the level is unchanged.
- Column sequencer (col_cnt, width ≥ clog2(GAP_COLS+1)):
  - On req with col_cnt==0 and the FIFO non-empty: pop, col_height<=head, col_cnt<=1.
  - On req with col_cnt==0 and the FIFO empty: col_height<=0, underflow<=1, col_cnt stays 0, so the pipe is emitted on the next req.
  - On req with 0<col_cnt<GAP_COLS: col_height<=0, col_cnt++.
  - On req with col_cnt==GAP_COLS: col_height<=0, col_cnt<=0 (wrap).
  - Result: the pattern is a pipe followed by exactly GAP_COLS zeros, repeating.
- Latency:
  - col_valid and col_height are registered, valid the cycle after req.
  - col_valid is high for exactly 1 cycle per req.
  - col_height holds its value until the next accepted req.
- Throughput: back-to-back req every cycle is legal. The underflow flag is how starvation is reported.
- Invariants:
  - Every non-zero col_height lies in [MIN_H, MAX_H].
  - Consecutive non-zero outputs differ by ≤ MAX_STEP.
  - The first pipe after reset or clear is within MAX_STEP of (MIN_H+MAX_H)/2.
- Arithmetic:
  - Height compare is done in 8 bits unsigned.
  - The absolute difference is computed as a mux of two subtractions, with no signed types.

Decomposition:
- Shared package:
  - Constants PIPE_OPENING=24 and PLAYFIELD_H=80.
  - The 7-bit column type (col_t).
  - The LFSR mask and DEF_SEED.
  - The datapath uses the same package.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/level). It is reusable and tested separately.
- LFSR and sequencer stay inline.

Test Plan:
- Reset/idle: hold resetn low mid-run with the FIFO at level 3 → all outputs 0 immediately (asynchronous), before the next clk edge. After release with no req, fifo_level reaches 4 and stays, with S_FULL reached.
- Gap pattern: GAP_COLS=3, FIFO full, issue 9 req spaced 5 cycles → col_height sequence is P,0,0,0,P,0,0,0,P, all with 10≤P≤50. col_valid pulses 9 times, each 1 cycle after its req.
- Range/step: 5000 columns with DEF_SEED, checked against a bench LFSR model → every pipe in [10,50], |Δ|≤20, and exact match to the model sequence.
- Underflow: clear then req on every cycle → the first pipe slot finds the FIFO empty: output 0, underflow=1, col_cnt still 0. The next req with level>0 yields a pipe. underflow stays 1 until the next clear.
- Seed: clear+seed_load with seed_in=0 → lfsr=16'hACE1. With seed_in=16'h1234 → the pipe sequence matches the model seeded 16'h1234.
- Priority: clear and req in the same cycle → no col_valid the next cycle, col_cnt=0, FIFO empty.
